pkt_steer_parser: RTL and testbench

//  Generalised successor of the 2-way HOP parser: steers each AXI4-Stream packet from the RX queue to one of
//  NUM_OUTPUTS masters (aggregation pipelines, OQs, CPU) via per-output ethertype/appcode match rules.

---
 rtl/pkt_steer_parser_pkg.sv | 22 ++
 rtl/pkt_steer_parser_fifo.sv | 59 +++++
 rtl/pkt_steer_parser_match.sv | 41 ++++
 rtl/pkt_steer_parser.sv | 157 +++++++++++++++
 tb/tb_pkt_steer_parser.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pkt_steer_parser_pkg.sv
// rtl/pkt_steer_parser_pkg.sv - shared types, counter width and helpers for the packet steering parser
package pkt_steer_parser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam int CNT_W = 32;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic rule_hit(input logic en, input logic use_or,
                                      input logic eth_eq, input logic app_eq);
        return en & (use_or ? (eth_eq | app_eq) : (eth_eq & app_eq));
    endfunction

endpackage

// File: rtl/pkt_steer_parser_fifo.sv
// rtl/pkt_steer_parser_fifo.sv - fall-through beat queue with early nearly-full flag
module pkt_steer_parser_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_BITS = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             nearly_full
);
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] FULL_LEVEL = (DEPTH_BITS+1)'(DEPTH);
    // Flag rises while two slots remain so an in-flight beat is never lost.
    localparam logic [DEPTH_BITS:0] NF_LEVEL   = (DEPTH_BITS+1)'(DEPTH - 2);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [DEPTH_BITS:0]   count;
    logic                  do_wr;
    logic                  do_rd;

    assign empty       = (count == '0);
    assign nearly_full = (count >= NF_LEVEL);
    assign do_wr       = wr_en && (count != FULL_LEVEL);
    assign do_rd       = rd_en && !empty;
    assign rd_data     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + DEPTH_BITS'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + DEPTH_BITS'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (DEPTH_BITS+1)'(1);
                2'b01:   count <= count - (DEPTH_BITS+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pkt_steer_parser_match.sv
// rtl/pkt_steer_parser_match.sv - per-output ethertype/appcode rule compare with lowest-index priority
module pkt_steer_parser_match
    import pkt_steer_parser_pkg::*;
#(
    parameter int NUM_OUTPUTS    = 3,
    parameter int APP_CODE_WIDTH = 2
) (
    input  logic [15:0]                            eth_field,
    input  logic [APP_CODE_WIDTH-1:0]              app_field,
    input  logic [NUM_OUTPUTS-1:0]                 cfg_rule_en,
    input  logic [NUM_OUTPUTS-1:0]                 cfg_match_or,
    input  logic [16*NUM_OUTPUTS-1:0]              cfg_ethertype,
    input  logic [APP_CODE_WIDTH*NUM_OUTPUTS-1:0]  cfg_appcode,
    output logic                                   hit,
    output logic [NUM_OUTPUTS-1:0]                 dest_onehot
);
    logic [NUM_OUTPUTS-1:0] rule_hits;

    always_comb begin
        rule_hits = '0;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            rule_hits[k] = rule_hit(cfg_rule_en[k], cfg_match_or[k],
                                    eth_field == cfg_ethertype[16*k +: 16],
                                    app_field == cfg_appcode[APP_CODE_WIDTH*k +: APP_CODE_WIDTH]);
        end
    end

    // Walk from the top down so the lowest-numbered hitting rule is the one left standing.
    always_comb begin
        hit         = 1'b0;
        dest_onehot = '0;
        for (int k = NUM_OUTPUTS - 1; k >= 0; k--) begin
            if (rule_hits[k]) begin
                hit            = 1'b1;
                dest_onehot    = '0;
                dest_onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pkt_steer_parser.sv
// rtl/pkt_steer_parser.sv - steers whole packets from an input queue to one of several masters by match rules
module pkt_steer_parser
    import pkt_steer_parser_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_OUTPUTS        = 3,
    parameter int ETHER_TYPE_POS     = 96,
    parameter int APP_CODE_POS       = 112,
    parameter int APP_CODE_WIDTH     = 2,
    parameter int DEFAULT_PORT       = 0,
    parameter int FIFO_DEPTH_BITS    = 6
) (
    input  logic                                    axis_aclk,
    input  logic                                    axis_resetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]            s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]          s_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]           s_axis_tuser,
    input  logic                                    s_axis_tlast,
    input  logic                                    s_axis_tvalid,
    output logic                                    s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]          m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]           m_axis_tuser,
    output logic                                    m_axis_tlast,
    output logic [NUM_OUTPUTS-1:0]                  m_axis_tvalid,
    input  logic [NUM_OUTPUTS-1:0]                  m_axis_tready,
    input  logic [NUM_OUTPUTS-1:0]                  cfg_rule_en,
    input  logic [NUM_OUTPUTS-1:0]                  cfg_match_or,
    input  logic [16*NUM_OUTPUTS-1:0]               cfg_ethertype,
    input  logic [APP_CODE_WIDTH*NUM_OUTPUTS-1:0]   cfg_appcode,
    input  logic                                    cfg_drop_unmatched,
    input  logic                                    stat_clear,
    output logic [CNT_W-1:0]                        stat_pkt_in,
    output logic [CNT_W*NUM_OUTPUTS-1:0]            stat_pkt_out,
    output logic [CNT_W-1:0]                        stat_pkt_drop
);
    localparam int KW = C_AXIS_DATA_WIDTH / 8;
    localparam int FW = C_AXIS_DATA_WIDTH + KW + C_AXIS_TUSER_WIDTH + 1;
    localparam logic [NUM_OUTPUTS-1:0] DEFAULT_ONEHOT = NUM_OUTPUTS'(1) << DEFAULT_PORT;

    state_t                   state;
    logic [NUM_OUTPUTS-1:0]   dest;
    logic                     fifo_empty;
    logic                     fifo_nearly_full;
    logic                     fifo_wr;
    logic                     pop;
    logic [FW-1:0]            head;
    logic                     match_hit;
    logic [NUM_OUTPUTS-1:0]   match_dest;
    logic [CNT_W-1:0]         cnt_in;
    logic [CNT_W-1:0]         cnt_drop;
    logic [CNT_W-1:0]         cnt_out [NUM_OUTPUTS];

    assign s_axis_tready = !fifo_nearly_full;
    assign fifo_wr       = s_axis_tvalid && s_axis_tready;

    pkt_steer_parser_fifo #(
        .WIDTH      (FW),
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk         (axis_aclk),
        .rst_n       (axis_resetn),
        .wr_en       (fifo_wr),
        .wr_data     ({s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata}),
        .rd_en       (pop),
        .rd_data     (head),
        .empty       (fifo_empty),
        .nearly_full (fifo_nearly_full)
    );

    assign {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata} = head;

    pkt_steer_parser_match #(
        .NUM_OUTPUTS    (NUM_OUTPUTS),
        .APP_CODE_WIDTH (APP_CODE_WIDTH)
    ) u_match (
        .eth_field     (m_axis_tdata[ETHER_TYPE_POS +: 16]),
        .app_field     (m_axis_tdata[APP_CODE_POS +: APP_CODE_WIDTH]),
        .cfg_rule_en   (cfg_rule_en),
        .cfg_match_or  (cfg_match_or),
        .cfg_ethertype (cfg_ethertype),
        .cfg_appcode   (cfg_appcode),
        .hit           (match_hit),
        .dest_onehot   (match_dest)
    );

    assign m_axis_tvalid = (state == ST_FWD && !fifo_empty) ? dest : '0;
    assign pop = !fifo_empty &&
                 ((state == ST_FWD && |(dest & m_axis_tready)) || state == ST_DROP);

    // Routing is decided once per packet from its head beat; the config is not looked at again until the next IDLE.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state <= ST_IDLE;
            dest  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        if (match_hit) begin
                            dest  <= match_dest;
                            state <= ST_FWD;
                        end else if (cfg_drop_unmatched) begin
                            dest  <= '0;
                            state <= ST_DROP;
                        end else begin
                            dest  <= DEFAULT_ONEHOT;
                            state <= ST_FWD;
                        end
                    end
                end
                ST_FWD, ST_DROP: begin
                    if (pop && m_axis_tlast) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            cnt_in   <= '0;
            cnt_drop <= '0;
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                cnt_out[k] <= '0;
            end
        end else if (stat_clear) begin
            cnt_in   <= '0;
            cnt_drop <= '0;
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                cnt_out[k] <= '0;
            end
        end else begin
            if (fifo_wr && s_axis_tlast) begin
                cnt_in <= sat_inc(cnt_in);
            end
            if (state == ST_DROP && pop && m_axis_tlast) begin
                cnt_drop <= sat_inc(cnt_drop);
            end
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                if (state == ST_FWD && pop && m_axis_tlast && dest[k]) begin
                    cnt_out[k] <= sat_inc(cnt_out[k]);
                end
            end
        end
    end

    assign stat_pkt_in   = cnt_in;
    assign stat_pkt_drop = cnt_drop;
    for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_stat
        assign stat_pkt_out[CNT_W*k +: CNT_W] = cnt_out[k];
    end

endmodule

// File: tb/tb_pkt_steer_parser.sv
// tb/tb_pkt_steer_parser.sv - directed self-checking bench for pkt_steer_parser
`timescale 1ns/1ps
module tb_pkt_steer_parser;
    localparam int DW = 256;
    localparam int KW = 32;
    localparam int UW = 128;
    localparam int N  = 3;
    localparam int AW = 2;

    logic            axis_aclk = 1'b0;
    logic            axis_resetn = 1'b0;
    logic [DW-1:0]   s_axis_tdata;
    logic [KW-1:0]   s_axis_tkeep;
    logic [UW-1:0]   s_axis_tuser;
    logic            s_axis_tlast;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic [DW-1:0]   m_axis_tdata;
    logic [KW-1:0]   m_axis_tkeep;
    logic [UW-1:0]   m_axis_tuser;
    logic            m_axis_tlast;
    logic [N-1:0]    m_axis_tvalid;
    logic [N-1:0]    m_axis_tready;
    logic [N-1:0]    cfg_rule_en;
    logic [N-1:0]    cfg_match_or;
    logic [16*N-1:0] cfg_ethertype;
    logic [AW*N-1:0] cfg_appcode;
    logic            cfg_drop_unmatched;
    logic            stat_clear;
    logic [31:0]     stat_pkt_in;
    logic [32*N-1:0] stat_pkt_out;
    logic [31:0]     stat_pkt_drop;

    int errors = 0;
    int checks = 0;
    int acc;
    int pops;
    int bad;
    logic seen_last;

    always #5 axis_aclk = ~axis_aclk;

    pkt_steer_parser dut (
        .axis_aclk          (axis_aclk),
        .axis_resetn        (axis_resetn),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tkeep       (s_axis_tkeep),
        .s_axis_tuser       (s_axis_tuser),
        .s_axis_tlast       (s_axis_tlast),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tready      (s_axis_tready),
        .m_axis_tdata       (m_axis_tdata),
        .m_axis_tkeep       (m_axis_tkeep),
        .m_axis_tuser       (m_axis_tuser),
        .m_axis_tlast       (m_axis_tlast),
        .m_axis_tvalid      (m_axis_tvalid),
        .m_axis_tready      (m_axis_tready),
        .cfg_rule_en        (cfg_rule_en),
        .cfg_match_or       (cfg_match_or),
        .cfg_ethertype      (cfg_ethertype),
        .cfg_appcode        (cfg_appcode),
        .cfg_drop_unmatched (cfg_drop_unmatched),
        .stat_clear         (stat_clear),
        .stat_pkt_in        (stat_pkt_in),
        .stat_pkt_out       (stat_pkt_out),
        .stat_pkt_drop      (stat_pkt_drop)
    );

    function automatic logic [DW-1:0] mk_beat(input logic [15:0] eth, input logic [1:0] app,
                                              input logic [31:0] tag);
        logic [DW-1:0] b;
        b          = '0;
        b[31:0]    = tag;
        b[96 +: 16] = eth;
        b[112 +: 2] = app;
        return b;
    endfunction

    task automatic chk_v(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_c(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge axis_aclk);
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic l);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, '0, 1'b0);
        s_axis_tkeep       = '1;
        s_axis_tuser       = '0;
        m_axis_tready      = '0;
        cfg_rule_en        = '0;
        cfg_match_or       = '0;
        cfg_ethertype      = '0;
        cfg_appcode        = '0;
        cfg_drop_unmatched = 1'b0;
        stat_clear         = 1'b0;

        // reset state
        repeat (3) tick();
        chk_v("rst_tvalid", m_axis_tvalid, 3'b000);
        chk_c("rst_pkt_in", stat_pkt_in, 32'd0);
        chk_c("rst_pkt_drop", stat_pkt_drop, 32'd0);
        chk_c("rst_pkt_out0", stat_pkt_out[31:0], 32'd0);
        axis_resetn = 1'b1;
        tick();
        chk_c("rst_s_tready", 32'(s_axis_tready), 32'd1);

        // rule 1: eth 0x8888 AND app 01, 3-beat packet, latency 2
        cfg_rule_en   = 3'b010;
        cfg_match_or  = 3'b000;
        cfg_ethertype = 48'h0000_8888_0000;
        cfg_appcode   = 6'b00_01_00;
        m_axis_tready = 3'b111;
        s_axis_tuser  = 128'h5A5A;
        drive(1'b1, mk_beat(16'h8888, 2'b01, 32'h101), 1'b0);
        tick();
        chk_v("t1_not_yet", m_axis_tvalid, 3'b000);
        drive(1'b1, mk_beat(16'h0000, 2'b00, 32'h102), 1'b0);
        tick();
        chk_v("t1_v0", m_axis_tvalid, 3'b010);
        chk_d("t1_d0", m_axis_tdata, mk_beat(16'h8888, 2'b01, 32'h101));
        chk_c("t1_tuser", m_axis_tuser[31:0], 32'h5A5A);
        drive(1'b1, mk_beat(16'h0000, 2'b00, 32'h103), 1'b1);
        tick();
        chk_v("t1_v1", m_axis_tvalid, 3'b010);
        chk_d("t1_d1", m_axis_tdata, mk_beat(16'h0000, 2'b00, 32'h102));
        drive(1'b0, '0, 1'b0);
        tick();
        chk_d("t1_d2", m_axis_tdata, mk_beat(16'h0000, 2'b00, 32'h103));
        chk_c("t1_tlast", 32'(m_axis_tlast), 32'd1);
        tick();
        chk_v("t1_idle", m_axis_tvalid, 3'b000);
        chk_c("t1_out1", stat_pkt_out[63:32], 32'd1);
        chk_c("t1_pkt_in", stat_pkt_in, 32'd1);

        // rules 1 and 2 both hit; rule 1 has priority
        cfg_rule_en   = 3'b110;
        cfg_match_or  = 3'b100;
        cfg_ethertype = 48'h8888_8888_0000;
        cfg_appcode   = 6'b11_01_00;
        drive(1'b1, mk_beat(16'h8888, 2'b01, 32'h201), 1'b1);
        tick();
        drive(1'b0, '0, 1'b0);
        tick();
        chk_v("t2_prio", m_axis_tvalid, 3'b010);
        tick();
        chk_c("t2_out1", stat_pkt_out[63:32], 32'd2);
        chk_c("t2_out2", stat_pkt_out[95:64], 32'd0);

        // unmatched dropped, then unmatched to default port
        cfg_appcode        = 6'b10_01_00;
        cfg_drop_unmatched = 1'b1;
        drive(1'b1, mk_beat(16'h0800, 2'b11, 32'h301), 1'b0);
        tick();
        drive(1'b1, mk_beat(16'h0000, 2'b00, 32'h302), 1'b1);
        tick();
        drive(1'b0, '0, 1'b0);
        chk_v("t3_drop_nv0", m_axis_tvalid, 3'b000);
        tick();
        chk_v("t3_drop_nv1", m_axis_tvalid, 3'b000);
        tick();
        chk_c("t3_drop_cnt", stat_pkt_drop, 32'd1);
        chk_v("t3_drop_nv2", m_axis_tvalid, 3'b000);
        cfg_drop_unmatched = 1'b0;
        drive(1'b1, mk_beat(16'h0800, 2'b11, 32'h311), 1'b1);
        tick();
        drive(1'b0, '0, 1'b0);
        tick();
        chk_v("t3_default", m_axis_tvalid, 3'b001);
        chk_d("t3_default_d", m_axis_tdata, mk_beat(16'h0800, 2'b11, 32'h311));
        tick();
        chk_c("t3_out0", stat_pkt_out[31:0], 32'd1);

        // backpressure on output 1; other outputs' ready ignored
        cfg_rule_en   = 3'b010;
        cfg_match_or  = 3'b000;
        cfg_ethertype = 48'h0000_8888_0000;
        cfg_appcode   = 6'b00_01_00;
        m_axis_tready = 3'b101;
        drive(1'b1, mk_beat(16'h8888, 2'b01, 32'h401), 1'b0);
        tick();
        drive(1'b1, mk_beat(16'h0000, 2'b00, 32'h402), 1'b0);
        tick();
        chk_v("t4_v", m_axis_tvalid, 3'b010);
        drive(1'b1, mk_beat(16'h0000, 2'b00, 32'h403), 1'b1);
        tick();
        drive(1'b0, '0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk_d("t4_hold_d", m_axis_tdata, mk_beat(16'h8888, 2'b01, 32'h401));
            chk_v("t4_hold_v", m_axis_tvalid, 3'b010);
            tick();
        end
        m_axis_tready = 3'b111;
        tick();
        chk_d("t4_d1", m_axis_tdata, mk_beat(16'h0000, 2'b00, 32'h402));
        tick();
        chk_d("t4_d2", m_axis_tdata, mk_beat(16'h0000, 2'b00, 32'h403));
        tick();
        chk_v("t4_idle", m_axis_tvalid, 3'b000);
        chk_c("t4_out1", stat_pkt_out[63:32], 32'd3);

        // fill to nearly-full with outputs stalled, then drain in order
        m_axis_tready = 3'b000;
        acc = 0;
        for (int i = 0; i < 80; i++) begin
            if (!s_axis_tready) break;
            drive(1'b1, (acc == 0) ? mk_beat(16'h8888, 2'b01, 32'd0)
                                   : mk_beat(16'h0000, 2'b00, 32'(acc)), acc == 61);
            acc++;
            tick();
        end
        drive(1'b0, '0, 1'b0);
        chk_c("t4_accepted", 32'(acc), 32'd62);
        chk_c("t4_nf_tready", 32'(s_axis_tready), 32'd0);
        m_axis_tready = 3'b010;
        pops = 0;
        bad = 0;
        seen_last = 1'b0;
        for (int i = 0; i < 100 && !seen_last; i++) begin
            if (m_axis_tvalid[1]) begin
                if (m_axis_tdata[31:0] !== 32'(pops)) bad++;
                if (m_axis_tlast) seen_last = 1'b1;
                pops++;
            end
            tick();
        end
        chk_c("t4_drain_cnt", 32'(pops), 32'd62);
        chk_c("t4_drain_order", 32'(bad), 32'd0);
        chk_c("t4_tready_back", 32'(s_axis_tready), 32'd1);
        chk_c("t4_out1_fill", stat_pkt_out[63:32], 32'd4);

        // back-to-back single-beat packets to 2,0,2 with clear colliding with an increment
        cfg_rule_en   = 3'b100;
        cfg_match_or  = 3'b000;
        cfg_ethertype = 48'h0901_0000_0000;
        cfg_appcode   = 6'b10_00_00;
        m_axis_tready = 3'b111;
        stat_clear    = 1'b1;
        drive(1'b1, mk_beat(16'h0901, 2'b10, 32'h501), 1'b1);
        tick();
        stat_clear = 1'b0;
        chk_c("t5_clear_in", stat_pkt_in, 32'd0);
        chk_c("t5_clear_out1", stat_pkt_out[63:32], 32'd0);
        chk_v("t5_n1", m_axis_tvalid, 3'b000);
        drive(1'b1, mk_beat(16'h1111, 2'b00, 32'h502), 1'b1);
        tick();
        chk_v("t5_a_v", m_axis_tvalid, 3'b100);
        chk_d("t5_a_d", m_axis_tdata, mk_beat(16'h0901, 2'b10, 32'h501));
        drive(1'b1, mk_beat(16'h0901, 2'b10, 32'h503), 1'b1);
        tick();
        drive(1'b0, '0, 1'b0);
        chk_v("t5_bubble1", m_axis_tvalid, 3'b000);
        tick();
        chk_v("t5_b_v", m_axis_tvalid, 3'b001);
        chk_d("t5_b_d", m_axis_tdata, mk_beat(16'h1111, 2'b00, 32'h502));
        tick();
        chk_v("t5_bubble2", m_axis_tvalid, 3'b000);
        tick();
        chk_v("t5_c_v", m_axis_tvalid, 3'b100);
        chk_d("t5_c_d", m_axis_tdata, mk_beat(16'h0901, 2'b10, 32'h503));
        tick();
        chk_c("t5_out0", stat_pkt_out[31:0], 32'd1);
        chk_c("t5_out1", stat_pkt_out[63:32], 32'd0);
        chk_c("t5_out2", stat_pkt_out[95:64], 32'd2);
        chk_c("t5_pkt_in", stat_pkt_in, 32'd2);

        // asynchronous reset mid-packet
        cfg_rule_en   = 3'b010;
        cfg_ethertype = 48'h0000_8888_0000;
        cfg_appcode   = 6'b00_01_00;
        m_axis_tready = 3'b000;
        drive(1'b1, mk_beat(16'h8888, 2'b01, 32'h601), 1'b0);
        tick();
        drive(1'b1, mk_beat(16'h0000, 2'b00, 32'h602), 1'b0);
        tick();
        drive(1'b0, '0, 1'b0);
        tick();
        chk_v("t6_pre", m_axis_tvalid, 3'b010);
        #2 axis_resetn = 1'b0;
        #1;
        chk_v("t6_rst_tvalid", m_axis_tvalid, 3'b000);
        chk_c("t6_rst_pkt_in", stat_pkt_in, 32'd0);
        chk_c("t6_rst_out2", stat_pkt_out[95:64], 32'd0);
        tick();
        axis_resetn   = 1'b1;
        m_axis_tready = 3'b111;
        drive(1'b1, mk_beat(16'h8888, 2'b01, 32'h677), 1'b1);
        tick();
        drive(1'b0, '0, 1'b0);
        tick();
        chk_v("t6_after_v", m_axis_tvalid, 3'b010);
        chk_d("t6_after_d", m_axis_tdata, mk_beat(16'h8888, 2'b01, 32'h677));
        chk_c("t6_after_last", 32'(m_axis_tlast), 32'd1);
        tick();
        chk_v("t6_idle", m_axis_tvalid, 3'b000);
        chk_c("t6_out1", stat_pkt_out[63:32], 32'd1);
        chk_c("t6_pkt_in", stat_pkt_in, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
